// File: rtl/param_cpu_core.sv
// Parametrised 4-register accumulator CPU with MEM_DEPTH x 8 program memory and run/pause/halt FSM.
// Optional single-step input i_STEP is present when CPU_SINGLE_STEP_EN is defined.
module param_cpu_core #(
  parameter  int DATA_W    = 8,
  parameter  int MEM_DEPTH = 256,
  localparam int PC_W      = $clog2(MEM_DEPTH)
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_RUN,
`ifdef CPU_SINGLE_STEP_EN
  input  logic              i_STEP,
`endif
  input  logic              i_PWE,
  input  logic [PC_W-1:0]   i_PADDR,
  input  logic [7:0]        i_PDATA,
  output logic [DATA_W-1:0] o_REG3,
  output logic [PC_W-1:0]   o_PC,
  output logic [1:0]        o_FLAGS,
  output logic              o_RUNNING,
  output logic              o_HALTED
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2} state_e;

  localparam logic [3:0] OP_JREL  = 4'b0001, OP_JZ    = 4'b0010, OP_MOVLO = 4'b0011;
  localparam logic [3:0] OP_MOVHI = 4'b0100, OP_MOV   = 4'b0101, OP_ADD   = 4'b0110;
  localparam logic [3:0] OP_SUB   = 4'b0111, OP_SHL   = 4'b1000, OP_SHR   = 4'b1001;
  localparam logic [3:0] OP_JC    = 4'b1010, OP_JNZ   = 4'b1011, OP_MOVSH = 4'b1100;
  localparam logic [3:0] OP_HLT   = 4'b1111;

  logic [7:0]        mem_q [MEM_DEPTH] = '{default: 8'h00};
  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d, jump_tgt;
  logic [DATA_W-1:0] regs_q [4];
  logic [DATA_W-1:0] regs_d [4];
  logic              c_q, c_d, z_q, z_d;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] diff;
  logic [7:0]        instr;
  logic [3:0]        op, imm;
  logic [1:0]        rd, rs;
  logic              step_go, exec_go;

  assign instr = mem_q[pc_q];
  assign op    = instr[3:0];
  assign imm   = instr[7:4];
  assign rd    = instr[7:6];
  assign rs    = instr[5:4];

`ifdef CPU_SINGLE_STEP_EN
  assign step_go = (state_q == S_IDLE) && !i_RUN && i_STEP;
`else
  assign step_go = 1'b0;
`endif
  // Dropping i_RUN in RUN returns to IDLE without committing the fetched instruction.
  assign exec_go = ((state_q == S_RUN) && i_RUN) || step_go;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    regs_d   = regs_q;
    c_d      = c_q;
    z_d      = z_q;
    sum      = {1'b0, regs_q[rd]} + {1'b0, regs_q[rs]};
    diff     = regs_q[rd] - regs_q[rs];
    jump_tgt = pc_q + PC_W'($signed(imm));
    case (state_q)
      S_IDLE:  if (i_RUN) state_d = S_RUN;
      S_RUN:   if (!i_RUN) state_d = S_IDLE;
      default: ;
    endcase
    if (exec_go) begin
      pc_d = pc_q + PC_W'(1);
      case (op)
        OP_JREL:  pc_d = jump_tgt;
        OP_JZ:    if (z_q) pc_d = jump_tgt;
        OP_JC:    if (c_q) pc_d = jump_tgt;
        OP_JNZ:   if (!z_q) pc_d = jump_tgt;
        OP_MOVLO: regs_d[0][3:0] = imm;
        OP_MOVHI: regs_d[0][7:4] = imm;
        OP_MOVSH: regs_d[0] = {regs_q[0][DATA_W-5:0], imm};
        OP_MOV:   regs_d[rd] = regs_q[rs];
        OP_ADD: begin
          regs_d[rd] = sum[DATA_W-1:0];
          c_d        = sum[DATA_W];
          z_d        = (sum[DATA_W-1:0] == '0);
        end
        OP_SUB: begin
          regs_d[rd] = diff;
          c_d        = (regs_q[rd] < regs_q[rs]);
          z_d        = (diff == '0);
        end
        OP_SHL:   regs_d[rs] = regs_q[rs] << instr[7:6];
        OP_SHR:   regs_d[rs] = regs_q[rs] >> instr[7:6];
        OP_HLT: begin
          pc_d    = pc_q;
          state_d = S_HALT;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      regs_q  <= '{default: '0};
      c_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      regs_q  <= regs_d;
      c_q     <= c_d;
      z_q     <= z_d;
    end
  end

  // Program memory survives reset; loading is only possible while the core is not running.
  always_ff @(posedge i_CLK) begin
    if (!i_RST && i_PWE && (state_q != S_RUN)) mem_q[i_PADDR] <= i_PDATA;
  end

  assign o_REG3    = regs_q[3];
  assign o_PC      = pc_q;
  assign o_FLAGS   = {c_q, z_q};
  assign o_RUNNING = (state_q == S_RUN);
  assign o_HALTED  = (state_q == S_HALT);

endmodule

// File: doc/param_cpu_core.md
Name: param_cpu_core

Overview:
- Parametrised successor of the team's 8-bit demo CPU.
- 4-register accumulator-style core with DATA_W-wide registers and a MEM_DEPTH x 8 program memory.
- Memory is loadable through a write port while the core is stopped.
- Adds synchronous reset, Z/C flags, conditional relative branches, a halt instruction and a run/pause control FSM.
- Sits at project top level; o_REG3 drives the user outputs.

Parameters:
- DATA_W, 8, register/ALU width; legal values are 8 to 32.
- MEM_DEPTH, 256, number of 8-bit program words; power of two, 16 to 256. PC_W = clog2(MEM_DEPTH).

Ports:
- i_CLK  in  1  clock, rising edge.
- i_RST  in  1  synchronous, active-high reset.
- i_RUN  in  1  level; high = execute, low = pause.
- i_PWE  in  1  program-memory write enable.
- i_PADDR  in  PC_W  program write address.
- i_PDATA  in  8  program write data.
- o_REG3  out  DATA_W  contents of r3.
- o_PC  out  PC_W  current PC.
- o_FLAGS  out  2  {C,Z}.
- o_RUNNING  out  1  state==RUN.
- o_HALTED  out  1  state==HALT.

Behaviour:
- Reset (i_RST=1 at posedge; dominates everything): PC=0, r0..r3=0, Z=C=0, state=IDLE. All outputs are 0 the cycle after reset. Memory contents are preserved across reset.
- Power-up memory contents are all 0x00 (NOP) in simulation.
- FSM:
  - IDLE -> RUN when i_RUN=1.
  - RUN -> IDLE when i_RUN=0; PC, registers and flags are held.
  - RUN -> HALT on executing HLT.
  - HALT is exited only by reset.
- Fetch: instr = MEM[PC], read combinationally. In RUN, one instruction commits per clock. No instruction executes in IDLE or HALT.
- Program writes: i_PWE commits MEM[i_PADDR]<=i_PDATA at posedge only when state!=RUN; writes in RUN are ignored. A write to MEM[PC] in IDLE is the instruction executed after resume.
- Encoding: op = instr[3:0], imm = instr[7:4], rd = instr[7:6], rs = instr[5:4].
  - 0000 NOP.
  - 0001 JREL: PC <= PC + sext(imm), modulo MEM_DEPTH, relative to the jump's own address. JREL 0 self-loops.
  - 0010 JZ, 1010 JC, 1011 JNZ: jump as JREL if the condition is true, else PC+1.
  - 0011 MOVLO: r0[3:0] <= imm.
  - 0100 MOVHI: r0[7:4] <= imm.
  - 1100 MOVSH: r0 <= {r0[DATA_W-5:0], imm}.
  - 0101 MOV: r[rd] <= r[rs].
  - 0110 ADD: r[rd] <= r[rd]+r[rs]; C = carry out; Z = (result==0).
  - 0111 SUB: r[rd] <= r[rd]-r[rs]; C = borrow (r[rd]<r[rs] unsigned); Z = (result==0).
  - 1000 SHL: r[rs] <= r[rs] << instr[7:6].
  - 1001 SHR: r[rs] <= r[rs] >> instr[7:6], logical. Shift by 0 leaves the register unchanged.
  - 1111 HLT: PC stays at the HLT address.
  - 1101, 1110: NOP.
- Register bits above bit 7 are untouched by MOVLO/MOVHI.
- Flags change only on ADD/SUB. A conditional branch uses the flags as committed before its cycle.
- rd==rs is legal: ADD doubles the register, SUB gives 0 with Z=1, C=0.
- Non-jump instructions advance PC by 1; PC wraps from MEM_DEPTH-1 to 0.

Optional Feature:
- Macro CPU_SINGLE_STEP_EN.
- Defined: adds input i_STEP (1 bit). In IDLE with i_RUN=0, i_STEP=1 executes exactly the instruction at PC in that cycle and the core stays in IDLE. If that instruction is HLT, the core goes to HALT.
- i_RUN=1 takes priority over i_STEP. i_STEP is ignored in RUN and HALT.
- Holding i_STEP high steps once per cycle.
- Undefined: the port does not exist; behaviour is otherwise identical.

Test Plan:
- Reset, load 0x53,0x14,0xC5,0x0F at 0..3, then i_RUN=1 -> after 4 run cycles: o_REG3=0x15, o_PC=3, o_HALTED=1, o_RUNNING=0. The core stays halted with i_RUN still high.
- Load MOVLO F, MOVHI F, MOV r1<=r0 (0x45), ADD r1+=r0 (0x46) -> r1=0xFE, {C,Z}=2'b10. Then SUB r1-=r1 (0x57) -> {C,Z}=2'b01. Then JZ +2 (0x22) skips the next word; verify with o_PC.
- JREL -1 (0xF1) at address 0, MEM_DEPTH=256 -> o_PC=0xFF next cycle. JREL 0 (0x01) -> o_PC constant.
- Drop i_RUN mid-program -> PC and regs freeze. An i_PWE write then lands in memory. A write attempted while RUN is ignored (readback via execution). Resume continues from the held PC.
- Assert i_RST in RUN and in HALT -> next cycle PC=0, regs=0, flags=0, IDLE. The program is still present: rerun gives the same o_REG3.
- DATA_W=16: MOVSH x4 with imm 1,2,3,4 then MOV r3<=r0 -> o_REG3=0x1234. With CPU_SINGLE_STEP_EN, four i_STEP pulses advance o_PC by exactly 4.
